// File: rtl/pe_conv_ctrl.sv
// pe_conv_ctrl: sequencer for a 5x5-kernel PE; walks oc->ic->row->col and times psum/relu/quant/write sidebands
module pe_conv_ctrl #(
    parameter int OUT_W  = 28,
    parameter int OUT_H  = 28,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 6,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          issue_v,
    output logic [4:0]    if_row,
    output logic [4:0]    if_col,
    output logic [3:0]    ic_idx,
    output logic [3:0]    oc_idx,
    output logic [AW-1:0] psum_rd_addr,
    output logic          psum_zero,
    output logic          relu_en,
    output logic          quan_en,
    output logic          out_we,
    output logic          out_final,
    output logic [AW-1:0] out_addr
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state;
    logic drain_cnt;
    logic col_last, row_last, ic_last, oc_last, pix_last, last;
    logic v1, fin1, first1, v2, fin2;
    logic [AW-1:0] a1, a2;
    assign col_last = if_col == 5'(OUT_W - 1);
    assign row_last = if_row == 5'(OUT_H - 1);
    assign ic_last  = ic_idx == 4'(IN_CH - 1);
    assign oc_last  = oc_idx == 4'(OUT_CH - 1);
    assign pix_last = col_last && row_last;
    assign last     = pix_last && ic_last && oc_last;
    assign issue_v   = (state == RUN) && !hold;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = state == FIN;
    assign psum_zero = v1 && first1;
    assign out_we    = v2;
    assign out_final = v2 && fin2;
    assign relu_en   = out_final;
    assign quan_en   = out_final;
    assign out_addr  = v2 ? a2 : '0;
    // Control FSM and loop counters; psum_rd_addr tracks row*OUT_W+col incrementally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= 1'b0;
            if_row       <= '0;
            if_col       <= '0;
            ic_idx       <= '0;
            oc_idx       <= '0;
            psum_rd_addr <= '0;
        end else begin
            case (state)
                IDLE: state <= start ? RUN : IDLE;
                RUN: if (issue_v) begin
                    if_col       <= col_last ? '0 : if_col + 5'd1;
                    psum_rd_addr <= pix_last ? '0 : psum_rd_addr + 1'b1;
                    if (col_last) if_row <= row_last ? '0 : if_row + 5'd1;
                    if (pix_last) ic_idx <= ic_last ? '0 : ic_idx + 4'd1;
                    if (pix_last && ic_last) oc_idx <= oc_last ? '0 : oc_idx + 4'd1;
                    if (last) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    state     <= drain_cnt ? FIN : DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Two-stage sideband pipe aligning psum select and the write with the PE result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            fin1   <= 1'b0;
            first1 <= 1'b0;
            a1     <= '0;
            v2     <= 1'b0;
            fin2   <= 1'b0;
            a2     <= '0;
        end else begin
            v1     <= issue_v;
            fin1   <= ic_last;
            first1 <= ic_idx == '0;
            a1     <= psum_rd_addr;
            v2     <= v1;
            fin2   <= fin1;
            a2     <= a1;
        end
    end
endmodule
